spi_master_ctrl: RTL and testbench

Full-duplex, single-slave SPI master that produces SCLK, MOSI and CS for the downstream SPI slave stage and captures its MISO. A host-side start/busy/done handshake launches one 8-bit transfer. SCLK is derived from the system clock by a programmable divider. All four SPI modes are selectable by parameter, and the MODE value must match the attached slave.

---
 rtl/spi_master_ctrl.sv | 97 +++++++++
 tb/tb_spi_master_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - single-slave SPI master, one 8-bit full-duplex transfer per start
module spi_master_ctrl #(
    parameter logic [1:0] MODE    = 2'd3,
    parameter int         CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       MISO,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data
);
    localparam logic       CPOL     = MODE[1];
    localparam logic       CPHA     = MODE[0];
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t     state;
    logic [7:0] div_cnt;
    logic [3:0] edge_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic       div_wrap;
    logic       leading;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign leading  = ~edge_cnt[0];

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            edge_cnt <= 4'd0;
            tx_shift <= 8'd0;
            rx_shift <= 8'd0;
            SCLK     <= CPOL;
            MOSI     <= 1'b0;
            CS       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        tx_shift <= tx_data;
                        rx_shift <= 8'd0;
                        div_cnt  <= 8'd0;
                        edge_cnt <= 4'd0;
                        CS       <= 1'b0;
                        busy     <= 1'b1;
                        MOSI     <= CPHA ? 1'b0 : tx_data[7];
                    end
                end
                // The SETUP wait ends on the first divider wrap, which is also edge k=0.
                SETUP, XFER: begin
                    if (div_wrap) begin
                        div_cnt  <= 8'd0;
                        SCLK     <= ~SCLK;
                        edge_cnt <= edge_cnt + 4'd1;
                        state    <= (edge_cnt == 4'd15) ? HOLD : XFER;
                        if (leading != CPHA) begin
                            rx_shift <= {rx_shift[6:0], MISO};
                        end else if (CPHA || edge_cnt != 4'd15) begin
                            MOSI     <= CPHA ? tx_shift[7] : tx_shift[6];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_wrap) begin
                        div_cnt <= 8'd0;
                        state   <= IDLE;
                        CS      <= 1'b1;
                        MOSI    <= 1'b0;
                        rx_data <= rx_shift;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl across all four modes
module tb_spi_master_ctrl;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] start_v;
    logic [3:0] miso_v;
    logic [3:0] sclk_v;
    logic [3:0] mosi_v;
    logic [3:0] cs_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] lb;
    logic [7:0] tx_v    [4];
    logic [7:0] rx_v    [4];
    logic [7:0] sl_byte [4];
    logic       mon_en;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         mode;
        logic [7:0] tx;
        logic [7:0] rx;
        int         gap;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar m = 0; m < 4; m++) begin : g
        localparam logic CPOL = (m >= 2);
        localparam logic CPHA = (m % 2 == 1);
        logic       s_miso = 1'b0;
        logic [7:0] s_sh   = 8'd0;
        logic [7:0] s_rx   = 8'd0;
        logic       p_sclk = CPOL;
        logic       p_cs   = 1'b1;
        logic       p_mosi = 1'b0;
        int         nedge  = 0;
        int         t0     = 0;
        int         rise   = 0;

        spi_master_ctrl #(.MODE(2'(m)), .CLK_DIV(D)) dut (
            .CLK(clk), .reset(reset), .start(start_v[m]), .tx_data(tx_v[m]),
            .MISO(miso_v[m]), .SCLK(sclk_v[m]), .MOSI(mosi_v[m]), .CS(cs_v[m]),
            .busy(busy_v[m]), .done(done_v[m]), .rx_data(rx_v[m])
        );

        assign miso_v[m] = lb[m] ? mosi_v[m] : s_miso;

        // Slave model plus monitor: edge-detects the bus one step after each posedge.
        always @(posedge clk) begin
            exp_t e;
            logic launch;
            logic lead;
            #1;
            if (mon_en) begin
                if (cs_v[m] == 1'b0 && p_cs == 1'b1) begin
                    t0     = cyc;
                    nedge  = 0;
                    s_rx   = 8'd0;
                    s_sh   = sl_byte[m];
                    s_miso = CPHA ? 1'b0 : s_sh[7];
                    chk("busy_at_setup", 32'(busy_v[m]), 32'd1);
                    chk("sclk_idle_setup", 32'(sclk_v[m]), 32'(CPOL));
                    if (sb.size() > 0) begin
                        chk("setup_mosi", 32'(mosi_v[m]), CPHA ? 32'd0 : 32'(sb[0].tx[7]));
                        if (sb[0].gap > 0) chk("cs_high_gap", 32'(cyc - rise), 32'(sb[0].gap));
                    end
                end else if (cs_v[m] == 1'b0 && p_cs == 1'b0) begin
                    launch = 1'b0;
                    if (sclk_v[m] != p_sclk) begin
                        chk("edge_time", 32'(cyc - t0), 32'((nedge + 1) * D));
                        lead = (nedge % 2 == 0);
                        if (lead != CPHA) begin
                            s_rx = {s_rx[6:0], mosi_v[m]};
                        end else if (CPHA || nedge != 15) begin
                            launch = 1'b1;
                            if (CPHA) begin
                                s_miso = s_sh[7];
                                s_sh   = {s_sh[6:0], 1'b0};
                            end else begin
                                s_sh   = {s_sh[6:0], 1'b0};
                                s_miso = s_sh[7];
                            end
                        end
                        nedge++;
                    end
                    if (mosi_v[m] != p_mosi) chk("mosi_on_launch_edge", 32'(launch), 32'd1);
                end
                if (cs_v[m] == 1'b1 && p_cs == 1'b0) rise = cyc;
                if (busy_v[m] && done_v[m]) chk("busy_with_done", 32'd1, 32'd0);
                if (done_v[m]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_mode", 32'(m), 32'(e.mode));
                        chk("rx_data", 32'(rx_v[m]), 32'(e.rx));
                        chk("slave_received", 32'(s_rx), 32'(e.tx));
                        chk("done_time", 32'(cyc - t0), 32'(17 * D));
                        chk("edge_count", 32'(nedge), 32'd16);
                        chk("sclk_idle_done", 32'(sclk_v[m]), 32'(CPOL));
                        chk("cs_at_done", 32'(cs_v[m]), 32'd1);
                        chk("mosi_at_done", 32'(mosi_v[m]), 32'd0);
                    end
                end
            end
            p_cs   = cs_v[m];
            p_sclk = sclk_v[m];
            p_mosi = mosi_v[m];
        end
    end

    task automatic go(input int m, input logic [7:0] tx);
        start_v[m] = 1'b1;
        tx_v[m]    = tx;
        @(posedge clk);
        #1;
        start_v[m] = 1'b0;
    endtask

    task automatic wait_done(input int m);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done_v[m]) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input int m, input logic [7:0] tx, input logic [7:0] rx);
        sb.push_back('{mode: m, tx: tx, rx: rx, gap: 0});
        go(m, tx);
        wait_done(m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        start_v = 4'd0;
        lb      = 4'd0;
        mon_en  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_v[i]    = 8'd0;
            sl_byte[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            chk("rst_cs", 32'(cs_v[m]), 32'd1);
            chk("rst_sclk", 32'(sclk_v[m]), (m >= 2) ? 32'd1 : 32'd0);
            chk("rst_mosi", 32'(mosi_v[m]), 32'd0);
            chk("rst_busy", 32'(busy_v[m]), 32'd0);
            chk("rst_done", 32'(done_v[m]), 32'd0);
            chk("rst_rx", 32'(rx_v[m]), 32'd0);
        end
        mon_en = 1'b1;

        lb[3] = 1'b1;
        run(3, 8'hA5, 8'hA5);

        sl_byte[0] = 8'h3C;
        run(0, 8'hC3, 8'h3C);

        lb[1] = 1'b1;
        run(1, 8'h81, 8'h81);
        lb[2] = 1'b1;
        run(2, 8'h81, 8'h81);

        sb.push_back('{mode: 3, tx: 8'h55, rx: 8'h55, gap: 0});
        go(3, 8'h55);
        repeat (19) @(posedge clk);
        #1;
        start_v[3] = 1'b1;
        tx_v[3]    = 8'hFF;
        @(posedge clk);
        #1;
        start_v[3] = 1'b0;
        wait_done(3);
        repeat (20) @(posedge clk);
        #1;
        chk("single_done", 32'(sb.size()), 32'd0);

        go(3, 8'h5A);
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_cs", 32'(cs_v[3]), 32'd1);
        chk("abort_sclk", 32'(sclk_v[3]), 32'd1);
        chk("abort_mosi", 32'(mosi_v[3]), 32'd0);
        chk("abort_busy", 32'(busy_v[3]), 32'd0);
        chk("abort_rx", 32'(rx_v[3]), 32'd0);
        chk("abort_done", 32'(done_v[3]), 32'd0);
        reset = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        run(3, 8'h3C, 8'h3C);

        sb.push_back('{mode: 3, tx: 8'h12, rx: 8'h12, gap: 0});
        sb.push_back('{mode: 3, tx: 8'h34, rx: 8'h34, gap: 1});
        start_v[3] = 1'b1;
        tx_v[3]    = 8'h12;
        @(posedge clk);
        #1;
        tx_v[3] = 8'h34;
        wait_done(3);
        @(posedge clk);
        #1;
        start_v[3] = 1'b0;
        wait_done(3);
        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
